time_entry_ctrl: RTL and testbench

Consumer side of the keypad digit interface. Counts digit strobes from the keypad (`shift_pulse`) and watches the 4-digit BCD entry (`keypad_values`). When the user presses SET TIME or SET ALARM, it validates the entry as an HH:MM value and issues a one-cycle load strobe to the clock or alarm register. It then clears the keypad shift register through `reset_shift`, so the next entry starts empty.

---
 rtl/time_entry_ctrl_pkg.sv | 23 ++
 rtl/time_entry_ctrl_if.sv | 23 ++
 rtl/time_entry_ctrl_bcd_time_check.sv | 29 ++
 rtl/time_entry_ctrl.sv | 105 ++++++++++
 tb/tb_time_entry_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/time_entry_ctrl_pkg.sv
// rtl/time_entry_ctrl_pkg.sv - shared states, digit field positions and helpers for time entry
package alarm_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;

    // Digit field LSB positions within the 16-bit BCD entry.
    localparam int HT_LSB = 12;
    localparam int HO_LSB = 8;
    localparam int MT_LSB = 4;
    localparam int MO_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        CLEAR = 2'd2
    } state_t;

    function automatic logic [3:0] get_digit(input logic [15:0] bcd, input int lsb);
        return bcd[lsb +: DIGIT_W];
    endfunction

endpackage

// File: rtl/time_entry_ctrl_if.sv
// rtl/time_entry_ctrl_if.sv - keypad entry and load strobe bundle between keypad side and controller
interface time_entry_ctrl_if;
    logic [15:0] keypad_values;
    logic        shift_pulse;
    logic        set_time_btn;
    logic        set_alarm_btn;
    logic        reset_shift;
    logic        load_time;
    logic        load_alarm;
    logic        entry_error;
    logic [15:0] time_out;
    logic [2:0]  digit_count;

    modport master (
        output keypad_values, shift_pulse, set_time_btn, set_alarm_btn,
        input  reset_shift, load_time, load_alarm, entry_error, time_out, digit_count
    );

    modport slave (
        input  keypad_values, shift_pulse, set_time_btn, set_alarm_btn,
        output reset_shift, load_time, load_alarm, entry_error, time_out, digit_count
    );
endinterface

// File: rtl/time_entry_ctrl_bcd_time_check.sv
// rtl/time_entry_ctrl_bcd_time_check.sv - combinational HH:MM BCD legality check
module bcd_time_check
    import alarm_pkg::*;
#(
    parameter int MAX_HOUR = 23,
    parameter int MAX_MIN  = 59
) (
    input  logic [15:0] i_bcd,
    output logic        o_valid
);
    logic [3:0] w_ht, w_ho, w_mt, w_mo;
    logic [7:0] w_hour, w_min;
    logic       w_digits_ok, w_hour_ok, w_min_ok;

    assign w_ht = get_digit(i_bcd, HT_LSB);
    assign w_ho = get_digit(i_bcd, HO_LSB);
    assign w_mt = get_digit(i_bcd, MT_LSB);
    assign w_mo = get_digit(i_bcd, MO_LSB);

    assign w_hour = ({4'd0, w_ht} * 8'd10) + {4'd0, w_ho};
    assign w_min  = ({4'd0, w_mt} * 8'd10) + {4'd0, w_mo};

    assign w_digits_ok = (w_ht <= 4'd9) && (w_ho <= 4'd9) && (w_mt <= 4'd9) && (w_mo <= 4'd9);
    // In 12-hour mode there is no hour zero.
    assign w_hour_ok   = (32'(w_hour) <= MAX_HOUR) && ((MAX_HOUR != 12) || (w_hour != 8'd0));
    assign w_min_ok    = (32'(w_min) <= MAX_MIN);

    assign o_valid = w_digits_ok && w_hour_ok && w_min_ok;
endmodule

// File: rtl/time_entry_ctrl.sv
// rtl/time_entry_ctrl.sv - counts keypad digits, validates HH:MM entry and issues load/clear strobes
module time_entry_ctrl
    import alarm_pkg::*;
#(
    parameter int MAX_HOUR = 23,
    parameter int MAX_MIN  = 59
) (
    input  logic                clk,
    input  logic                reset,
    time_entry_ctrl_if.slave    bus
);
    state_t      r_state, w_state;
    logic        r_time_prev, r_alarm_prev;
    logic        r_is_time, w_is_time;
    logic [2:0]  r_count, w_count;
    logic        r_reset_shift, w_reset_shift;
    logic        r_load_time, w_load_time;
    logic        r_load_alarm, w_load_alarm;
    logic        r_entry_error, w_entry_error;
    logic [15:0] r_time_out, w_time_out;
    logic        w_time_rise, w_alarm_rise, w_entry_ok;

    bcd_time_check #(.MAX_HOUR(MAX_HOUR), .MAX_MIN(MAX_MIN)) u_check (
        .i_bcd   (bus.keypad_values),
        .o_valid (w_entry_ok)
    );

    assign w_time_rise  = bus.set_time_btn  && !r_time_prev;
    assign w_alarm_rise = bus.set_alarm_btn && !r_alarm_prev;

    always_comb begin
        w_state       = r_state;
        w_is_time     = r_is_time;
        w_count       = r_count;
        w_reset_shift = 1'b0;
        w_load_time   = 1'b0;
        w_load_alarm  = 1'b0;
        w_entry_error = 1'b0;
        w_time_out    = r_time_out;
        case (r_state)
            IDLE: begin
                if (bus.shift_pulse && (r_count != 3'(NUM_DIGITS)))
                    w_count = r_count + 3'd1;
                // Time request has priority over a simultaneous alarm request.
                if (w_time_rise) begin
                    w_state   = CHECK;
                    w_is_time = 1'b1;
                end else if (w_alarm_rise) begin
                    w_state   = CHECK;
                    w_is_time = 1'b0;
                end
            end
            CHECK: begin
                w_state       = CLEAR;
                w_count       = 3'd0;
                w_reset_shift = 1'b1;
                if ((r_count == 3'(NUM_DIGITS)) && w_entry_ok) begin
                    w_load_time  = r_is_time;
                    w_load_alarm = !r_is_time;
                    w_time_out   = bus.keypad_values;
                end else begin
                    w_entry_error = 1'b1;
                end
            end
            CLEAR: begin
                w_state = IDLE;
                w_count = 3'd0;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_time_prev   <= 1'b0;
            r_alarm_prev  <= 1'b0;
            r_is_time     <= 1'b0;
            r_count       <= 3'd0;
            r_reset_shift <= 1'b0;
            r_load_time   <= 1'b0;
            r_load_alarm  <= 1'b0;
            r_entry_error <= 1'b0;
            r_time_out    <= 16'h0000;
        end else begin
            r_state       <= w_state;
            r_time_prev   <= bus.set_time_btn;
            r_alarm_prev  <= bus.set_alarm_btn;
            r_is_time     <= w_is_time;
            r_count       <= w_count;
            r_reset_shift <= w_reset_shift;
            r_load_time   <= w_load_time;
            r_load_alarm  <= w_load_alarm;
            r_entry_error <= w_entry_error;
            r_time_out    <= w_time_out;
        end
    end

    assign bus.reset_shift = r_reset_shift;
    assign bus.load_time   = r_load_time;
    assign bus.load_alarm  = r_load_alarm;
    assign bus.entry_error = r_entry_error;
    assign bus.time_out    = r_time_out;
    assign bus.digit_count = r_count;
endmodule

// File: tb/tb_time_entry_ctrl.sv
// tb/tb_time_entry_ctrl.sv - self-checking bench for time_entry_ctrl
module tb_time_entry_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    time_entry_ctrl_if bus();

    time_entry_ctrl #(.MAX_HOUR(23), .MAX_MIN(59)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          pulses;
        logic [15:0] kv;
        bit          tbtn;
        bit          abtn;
        bit          lt;
        bit          la;
        bit          err;
        logic [15:0] tout;
    } vec_t;

    vec_t vecs[10];
    int checks = 0;
    int failures = 0;

    // Reference model state
    int          m_phase, m_cnt;
    bit          m_tprev, m_aprev, m_is_time;
    logic [15:0] m_time_out;
    bit          e_lt, e_la, e_err, e_rs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic bit ref_valid(input logic [15:0] v, input int cnt);
        int d[4];
        int hour, minute;
        for (int i = 0; i < 4; i++) d[i] = int'((v >> (12 - 4 * i)) & 16'h000F);
        if (cnt != 4) return 1'b0;
        for (int i = 0; i < 4; i++) if (d[i] > 9) return 1'b0;
        hour   = d[0] * 10 + d[1];
        minute = d[2] * 10 + d[3];
        return (hour <= 23) && (minute <= 59);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_tprev = 0; m_aprev = 0; m_is_time = 0;
        m_time_out = 16'h0000; e_lt = 0; e_la = 0; e_err = 0; e_rs = 0;
    endtask

    task automatic model_edge();
        bit tr, ar, ok;
        tr = bus.set_time_btn && !m_tprev;
        ar = bus.set_alarm_btn && !m_aprev;
        case (m_phase)
            0: begin
                e_lt = 0; e_la = 0; e_err = 0; e_rs = 0;
                if (bus.shift_pulse && m_cnt < 4) m_cnt++;
                if (tr) begin m_phase = 1; m_is_time = 1; end
                else if (ar) begin m_phase = 1; m_is_time = 0; end
            end
            1: begin
                ok = ref_valid(bus.keypad_values, m_cnt);
                e_lt = ok && m_is_time; e_la = ok && !m_is_time; e_err = !ok; e_rs = 1;
                if (ok) m_time_out = bus.keypad_values;
                m_cnt = 0; m_phase = 2;
            end
            default: begin
                e_lt = 0; e_la = 0; e_err = 0; e_rs = 0;
                m_cnt = 0; m_phase = 0;
            end
        endcase
        m_tprev = bus.set_time_btn;
        m_aprev = bus.set_alarm_btn;
    endtask

    function automatic logic [31:0] dut_state();
        return {9'd0, bus.load_time, bus.load_alarm, bus.entry_error, bus.reset_shift,
                bus.digit_count, bus.time_out};
    endfunction

    function automatic logic [31:0] model_state();
        return {9'd0, e_lt, e_la, e_err, e_rs, 3'(m_cnt), m_time_out};
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset(); else model_edge();
        @(negedge clk);
        check("model", dut_state(), model_state());
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            bus.shift_pulse = 1'b1;
            cycle();
        end
        bus.shift_pulse = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bus.keypad_values = v.kv;
        pulses(v.pulses);
        bus.set_time_btn  = v.tbtn;
        bus.set_alarm_btn = v.abtn;
        cycle();
        check("pre_strobe", {bus.load_time, bus.load_alarm, bus.entry_error, bus.reset_shift}, 4'b0000);
        cycle();
        check("vec_strobes", {bus.load_time, bus.load_alarm, bus.entry_error, bus.reset_shift},
              {v.lt, v.la, v.err, 1'b1});
        check("vec_time_out", bus.time_out, v.tout);
        check("vec_count", bus.digit_count, 3'd0);
        bus.set_time_btn  = 1'b0;
        bus.set_alarm_btn = 1'b0;
        cycle();
        check("post_strobe", {bus.load_time, bus.load_alarm, bus.entry_error, bus.reset_shift}, 4'b0000);
        cycle();
    endtask

    initial begin
        int nlt, nla;
        vec_t v;
        vecs[0] = '{4, 16'h1234, 1, 0, 1, 0, 0, 16'h1234};
        vecs[1] = '{4, 16'h2460, 0, 1, 0, 0, 1, 16'h1234};
        vecs[2] = '{3, 16'h0123, 1, 0, 0, 0, 1, 16'h1234};
        vecs[3] = '{4, 16'h0730, 1, 1, 1, 0, 0, 16'h0730};
        vecs[4] = '{4, 16'h2359, 0, 1, 0, 1, 0, 16'h2359};
        vecs[5] = '{4, 16'h2400, 1, 0, 0, 0, 1, 16'h2359};
        vecs[6] = '{4, 16'h1A00, 0, 1, 0, 0, 1, 16'h2359};
        vecs[7] = '{4, 16'h0000, 0, 1, 0, 1, 0, 16'h0000};
        vecs[8] = '{4, 16'h1960, 1, 0, 0, 0, 1, 16'h0000};
        vecs[9] = '{6, 16'h1959, 1, 0, 1, 0, 0, 16'h1959};

        reset = 1'b1;
        bus.keypad_values = 16'h0000;
        bus.shift_pulse   = 1'b0;
        bus.set_time_btn  = 1'b0;
        bus.set_alarm_btn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_outputs", dut_state(), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Saturation of the digit counter
        pulses(6);
        check("sat_count", bus.digit_count, 3'd4);
        v = '{0, 16'h1234, 1, 0, 1, 0, 0, 16'h1234};
        run_vec(v);

        // Both buttons held high: exactly one time strobe, no alarm strobe
        bus.keypad_values = 16'h0730;
        pulses(4);
        bus.set_time_btn = 1'b1;
        bus.set_alarm_btn = 1'b1;
        nlt = 0; nla = 0;
        repeat (12) begin
            cycle();
            nlt += int'(bus.load_time);
            nla += int'(bus.load_alarm);
        end
        check("hold_time_strobes", nlt, 1);
        check("hold_alarm_strobes", nla, 0);
        check("hold_time_out", bus.time_out, 16'h0730);
        bus.set_time_btn = 1'b0;
        bus.set_alarm_btn = 1'b0;
        cycle();

        // Reset mid-stream clears the count asynchronously
        pulses(2);
        check("mid_count", bus.digit_count, 3'd2);
        reset = 1'b1;
        #1;
        model_reset();
        check("reset_async", dut_state(), 32'h0);
        cycle();
        reset = 1'b0;

        // Reset while in CLEAR drops reset_shift and the strobe at once
        bus.keypad_values = 16'h1234;
        pulses(4);
        bus.set_time_btn = 1'b1;
        cycle();
        cycle();
        check("clear_rs_high", {bus.reset_shift, bus.load_time}, 2'b11);
        reset = 1'b1;
        bus.set_time_btn = 1'b0;
        #1;
        model_reset();
        check("clear_reset_async", dut_state(), 32'h0);
        cycle();
        reset = 1'b0;
        v = '{4, 16'h0945, 1, 0, 1, 0, 0, 16'h0945};
        run_vec(v);

        // Randomized stimulus against the reference model
        repeat (1500) begin
            bus.shift_pulse = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 1) == 0)
                bus.keypad_values = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                                     4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
            else
                bus.keypad_values = 16'($urandom);
            if ($urandom_range(0, 5) == 0) bus.set_time_btn = ~bus.set_time_btn;
            if ($urandom_range(0, 5) == 0) bus.set_alarm_btn = ~bus.set_alarm_btn;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                check("rand_reset", dut_state(), 32'h0);
            end else begin
                reset = 1'b0;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
